// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
//   sa_state_t        : sequencer FSM state encoding
//   SA_DEFAULT_WIDTH  : default operand/sum width in bits
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sa_state_t;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational; reused once per bit by the sequencer.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: adds two WIDTH-bit operands LSB first through a
// single full-adder cell, with an IDLE/RUN/DONE FSM and a bit counter.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ena             : advance enable; 0 freezes all state
//   start           : add request, accepted in IDLE or DONE
//   a_in, b_in, cin : operands and carry-in, captured on accept
//   busy            : high while in RUN
//   done            : one-cycle pulse on entry to DONE (held while ena=0)
//   sum_out, cout   : result and final carry, held until the next accept
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sa_state_t        state;
  sa_state_t        next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic             accept;
  logic             step;
  logic             fa_sum;
  logic             fa_cout;

  // Shared full-adder cell fed by the current LSBs and the running carry
  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath control
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (ena && start) begin
          next_state = S_RUN;
          accept     = 1'b1;
        end
      end
      S_RUN: begin
        if (ena) begin
          step = 1'b1;
          if (cnt == LAST_BIT) begin
            next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (ena) begin
          if (start) begin
            next_state = S_RUN;
            accept     = 1'b1;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand/sum shift registers, carry flop and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= a_in;
      b_sh   <= b_in;
      sum_sh <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      // Hold at the last index so the counter never wraps
      if (cnt != LAST_BIT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered status; done only rises on the RUN->DONE transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (ena) begin
      busy <= (next_state == S_RUN);
      done <= (state == S_RUN) && (next_state == S_DONE);
    end
  end

  assign sum_out = sum_sh;
  assign cout    = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic        use16;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  logic        busy_m, done_m, cout_m;
  logic [15:0] sum_m;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int pulses = 0;
  logic d8p = 1'b0;
  logic d16p = 1'b0;
  logic [15:0] last_sum;
  logic        last_cout;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (start & ~use16),
    .a_in    (a[7:0]),
    .b_in    (b[7:0]),
    .cin     (cin),
    .busy    (busy8),
    .done    (done8),
    .sum_out (sum8),
    .cout    (cout8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (start & use16),
    .a_in    (a),
    .b_in    (b),
    .cin     (cin),
    .busy    (busy16),
    .done    (done16),
    .sum_out (sum16),
    .cout    (cout16)
  );

  assign busy_m = use16 ? busy16 : busy8;
  assign done_m = use16 ? done16 : done8;
  assign cout_m = use16 ? cout16 : cout8;
  assign sum_m  = use16 ? sum16 : {8'h00, sum8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges of done on either instance
  always @(negedge clk) begin
    if (done8 && !d8p) pulses++;
    if (done16 && !d16p) pulses++;
    d8p  = done8;
    d16p = done16;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One add: accept edge, then run until done (optional ena gap, ignored
  // start, or mid-run reset). Leaves the DUT in DONE with start low.
  task automatic run_add(input logic [15:0] a_v, input logic [15:0] b_v, input logic c_v,
                         input int gap_at, input int gap_len, input int ign_at, input int rst_at);
    int lat;
    int w;
    logic [15:0] mask;
    logic [16:0] exp_v;
    logic busy_ok;
    w = use16 ? 16 : 8;
    mask = use16 ? 16'hFFFF : 16'h00FF;
    exp_v = 17'(a_v & mask) + 17'(b_v & mask) + 17'(c_v);
    a = a_v & mask;
    b = b_v & mask;
    cin = c_v;
    ena = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    accepts++;
    check("accept_busy", 32'(busy_m), 32'd1);
    check("accept_done", 32'(done_m), 32'd0);
    check("accept_sum_clr", 32'(sum_m), 32'd0);
    lat = 0;
    busy_ok = 1'b1;
    while (!done_m && lat < 200) begin
      if (!busy_m) busy_ok = 1'b0;
      if (lat == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_done", 32'(done_m), 32'd0);
        check("rst_sum", 32'(sum_m), 32'd0);
        check("rst_cout", 32'(cout_m), 32'd0);
        #2;
        rst_n = 1'b1;
        accepts--;
        return;
      end
      if (lat == gap_at) ena = 1'b0;
      if (lat == gap_at + gap_len) ena = 1'b1;
      if (lat == ign_at) begin
        start = 1'b1;
        a = 16'h0000;
        b = 16'h0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    ena = 1'b1;
    start = 1'b0;
    last_sum = exp_v[15:0] & mask;
    last_cout = use16 ? exp_v[16] : exp_v[8];
    check("latency", 32'(lat), 32'(w + gap_len));
    check("busy_during_run", 32'(busy_ok), 32'd1);
    check("done_busy", 32'(busy_m), 32'd0);
    check("sum", 32'(sum_m), 32'(last_sum));
    check("cout", 32'(cout_m), 32'(last_cout));
  endtask

  // DONE -> IDLE step: pulse gone, result held
  task automatic idle_step();
    ena = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_done", 32'(done_m), 32'd0);
    check("idle_busy", 32'(busy_m), 32'd0);
    check("idle_sum_hold", 32'(sum_m), 32'(last_sum));
    check("idle_cout_hold", 32'(cout_m), 32'(last_cout));
  endtask

  initial begin
    int w;
    int gl;
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    use16 = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #1;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_sum", 32'(sum8), 32'd0);
    check("reset_cout", 32'(cout8), 32'd0);
    check("reset_sum16", 32'(sum16), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add, then return to IDLE with result held
    run_add(16'h005A, 16'h003C, 1'b0, -1, 0, -1, -1);
    idle_step();
    // Carry-out boundaries
    run_add(16'h00FF, 16'h0001, 1'b0, -1, 0, -1, -1);
    idle_step();
    run_add(16'h00FF, 16'h00FF, 1'b1, -1, 0, -1, -1);
    idle_step();
    // Start mid-RUN ignored, then back-to-back start while in DONE
    run_add(16'h00A7, 16'h0039, 1'b1, -1, 0, 3, -1);
    run_add(16'h0081, 16'h0080, 1'b0, -1, 0, -1, -1);
    // done held while frozen in DONE
    ena = 1'b0;
    @(posedge clk); #1;
    check("done_hold1", 32'(done_m), 32'd1);
    @(posedge clk); #1;
    check("done_hold2", 32'(done_m), 32'd1);
    check("done_hold_sum", 32'(sum_m), 32'(last_sum));
    idle_step();
    // ena low for 3 cycles mid-RUN
    run_add(16'h0012, 16'h0034, 1'b0, 4, 3, -1, -1);
    idle_step();
    // Reset mid-RUN, then a clean add
    run_add(16'h005A, 16'h003C, 1'b0, -1, 0, -1, 4);
    check("post_rst_busy", 32'(busy_m), 32'd0);
    run_add(16'h0033, 16'h0044, 1'b1, -1, 0, -1, -1);
    idle_step();

    // Randomized adds at both widths against plain arithmetic
    for (int s = 0; s < 2; s++) begin
      use16 = (s == 1);
      w = use16 ? 16 : 8;
      for (int i = 0; i < 1000; i++) begin
        gl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        run_add(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, w - 1)), gl, -1, -1);
        if ($urandom_range(0, 1) == 1) idle_step();
      end
      idle_step();
    end

    @(posedge clk); #1;
    check("done_pulses", 32'(pulses), 32'(accepts));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
